dmem_be_ctrl: RTL and testbench

Parametrised data-memory controller for the single-cycle/multi-cycle CPU datapath. It replaces the fixed 64-entry word memory with a configurable-depth, byte-addressed, little-endian store. The store supports byte/half/word accesses, sign or zero extension on loads, and a programmable access latency behind a request/ready handshake. It sits between the ALU address output and the register-file write-back mux.

---
 rtl/dmem_be_ctrl_pkg.sv | 23 ++
 rtl/dmem_bank.sv | 27 ++
 rtl/dmem_be_ctrl.sv | 137 +++++++++++++
 tb/tb_dmem_be_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_be_ctrl_pkg.sv
// Shared size codes, FSM encoding and byte-lane helper for the data-memory controller.
package dmem_be_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Little-endian lane enables; size 11 falls through to a full word.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: lane_be = 4'b0001 << lo;
            SZ_HALF: lane_be = lo[1] ? 4'b1100 : 4'b0011;
            default: lane_be = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// DEPTH x 32 storage with per-byte write enables and a combinational word read.
// Contents are deliberately not reset.
module dmem_bank #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_be_ctrl.sv
// Byte-addressed little-endian data memory with LAT wait cycles behind a Req/Ready handshake.
// Optional alignment check enabled by defining DMEM_ALIGN_CHK_EN.
module dmem_be_ctrl
    import dmem_be_ctrl_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32,
    parameter int LAT    = 0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              MemWr,
    input  logic [ADDR_W-1:0] Ad,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [31:0]       WrData,
    output logic              Ready,
    output logic [31:0]       DM,
    output logic              Rvalid,
    output logic              Done,
    output logic              Misalign
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t           state;
    logic [3:0]       cnt;
    logic             wr_q;
    logic             uns_q;
    logic [1:0]       size_q;
    logic [IDX_W+1:0] ad_q;
    logic [31:0]      wdata_q;

    logic [31:0] rdata;
    logic [31:0] wlane;
    logic [31:0] shifted;
    logic [31:0] ld;
    logic [3:0]  be;
    logic        mis;
    logic        we;
    logic        unused_hi;

    // Address bits above the word index only alias, so they are dropped.
    assign unused_hi = ^Ad[ADDR_W-1:IDX_W+2];

    assign Ready = (state == ST_IDLE);
    assign be    = lane_be(size_q, ad_q[1:0]);

`ifdef DMEM_ALIGN_CHK_EN
    assign mis = ((size_q == SZ_HALF) && ad_q[0]) || (size_q[1] && (ad_q[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign we = (state == ST_ACCESS) && wr_q && !mis && !Reset;

    always_comb begin
        wlane   = wdata_q;
        shifted = rdata;
        ld      = rdata;
        case (size_q)
            SZ_BYTE: begin
                wlane   = {4{wdata_q[7:0]}};
                shifted = rdata >> {ad_q[1:0], 3'b000};
                ld      = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wlane   = {2{wdata_q[15:0]}};
                shifted = rdata >> {ad_q[1], 4'b0000};
                ld      = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    dmem_bank #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_bank (
        .clk   (Clk),
        .we    (we),
        .be    (be),
        .idx   (ad_q[IDX_W+1:2]),
        .wdata (wlane),
        .rdata (rdata)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            wr_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= SZ_BYTE;
            ad_q     <= '0;
            wdata_q  <= 32'd0;
            DM       <= 32'd0;
            Rvalid   <= 1'b0;
            Done     <= 1'b0;
            Misalign <= 1'b0;
        end else begin
            Rvalid   <= 1'b0;
            Done     <= 1'b0;
            Misalign <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Req) begin
                        wr_q    <= MemWr;
                        uns_q   <= Unsigned;
                        size_q  <= Size;
                        ad_q    <= Ad[IDX_W+1:0];
                        wdata_q <= WrData;
                        if (LAT > 0) begin
                            state <= ST_WAIT;
                            cnt   <= 4'(LAT - 1);
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_ACCESS;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_ACCESS: begin
                    Done     <= 1'b1;
                    Misalign <= mis;
                    if (!wr_q && !mis) begin
                        DM     <= ld;
                        Rvalid <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_be_ctrl.sv
// Two instances (LAT=0/DEPTH=256 and LAT=3/DEPTH=1024) checked against a byte-array model.
module tb_dmem_be_ctrl;

    logic        clk;
    logic        rst    [2];
    logic        req    [2];
    logic        wr_s   [2];
    logic [31:0] ad_s   [2];
    logic [1:0]  sz_s   [2];
    logic        uns_s  [2];
    logic [31:0] wd_s   [2];
    logic        ready  [2];
    logic [31:0] dm     [2];
    logic        rvalid [2];
    logic        done   [2];
    logic        mis    [2];

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mb      [2][4096];
    logic [31:0] last_dm [2];
    logic [31:0] got;

    dmem_be_ctrl #(.DEPTH(256), .ADDR_W(32), .LAT(0)) u_d0 (
        .Clk(clk), .Reset(rst[0]), .Req(req[0]), .MemWr(wr_s[0]), .Ad(ad_s[0]),
        .Size(sz_s[0]), .Unsigned(uns_s[0]), .WrData(wd_s[0]), .Ready(ready[0]),
        .DM(dm[0]), .Rvalid(rvalid[0]), .Done(done[0]), .Misalign(mis[0])
    );

    dmem_be_ctrl #(.DEPTH(1024), .ADDR_W(32), .LAT(3)) u_d1 (
        .Clk(clk), .Reset(rst[1]), .Req(req[1]), .MemWr(wr_s[1]), .Ad(ad_s[1]),
        .Size(sz_s[1]), .Unsigned(uns_s[1]), .WrData(wd_s[1]), .Ready(ready[1]),
        .DM(dm[1]), .Rvalid(rvalid[1]), .Done(done[1]), .Misalign(mis[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int span_of(input int d);
        return (d == 0) ? 1024 : 4096;
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit misal(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_ALIGN_CHK_EN
        return (a % nbytes(sz)) != 0;
`else
        return (a == 32'hFFFF_FFFF) && (sz == 2'b11) && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_load(input int d, input logic [31:0] a,
                                               input logic [1:0] sz, input bit u);
        int n = nbytes(sz);
        int base = int'(a % span_of(d)) / n * n;
        logic [31:0] v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[d][base + i]) << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    task automatic model_store(input int d, input logic [31:0] a, input logic [1:0] sz,
                               input logic [31:0] wd);
        int n = nbytes(sz);
        int base = int'(a % span_of(d)) / n * n;
        for (int i = 0; i < n; i++) mb[d][base + i] = wd[8*i +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access; when hold=1 Req stays high (with new address) until Done.
    task automatic access(input int d, input bit wr, input logic [31:0] a, input logic [1:0] sz,
                          input bit u, input logic [31:0] wd, input bit hold,
                          output logic [31:0] res);
        int k, lowc;
        bit m;
        logic [31:0] e;
        k = 0;
        while (!ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("ready_before_req", 32'(ready[d]), 32'd1);
        m = misal(a, sz);
        e = (wr || m) ? last_dm[d] : model_load(d, a, sz, u);
        req[d] = 1'b1; wr_s[d] = wr; ad_s[d] = a; sz_s[d] = sz; uns_s[d] = u; wd_s[d] = wd;
        @(posedge clk);
        #1;
        if (hold) begin
            ad_s[d] = a ^ 32'h0000_0010;
            sz_s[d] = 2'b00;
        end else begin
            req[d]  = 1'b0;
            ad_s[d] = $urandom;
            wd_s[d] = $urandom;
            wr_s[d] = 1'($urandom);
        end
        k = 0;
        lowc = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) check("done_pulse_width", 32'(done[d]), 32'd0);
            if (!ready[d]) lowc++;
        end while (!done[d] && k < 40);
        check("latency", 32'(k - 1), 32'(lat_of(d) + 1));
        check("ready_low_cycles", 32'(lowc), 32'(lat_of(d) + 1));
        check("ready_at_done", 32'(ready[d]), 32'd1);
        check("rvalid", 32'(rvalid[d]), 32'(!(wr || m)));
        check("misalign", 32'(mis[d]), 32'(m));
        check("dm", dm[d], e);
        if (wr && !m) model_store(d, a, sz, wd);
        if (!(wr || m)) last_dm[d] = e;
        res = dm[d];
        if (hold) begin
            req[d] = 1'b0;
            @(negedge clk);
            check("held_req_ignored", 32'({ready[d], done[d]}), 32'b10);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; wr_s[d] = 1'b0; ad_s[d] = 32'd0;
            sz_s[d] = 2'b00; uns_s[d] = 1'b0; wd_s[d] = 32'd0; last_dm[d] = 32'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("reset_outputs", {ready[d], rvalid[d], done[d], mis[d]}, 32'b1000);
            check("reset_dm", dm[d], 32'd0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        // LAT=0 byte/half steering and extension
        access(0, 1, 32'h10, 2'b10, 0, 32'hDEAD_BEEF, 0, got);
        access(0, 0, 32'h11, 2'b00, 1, 32'h0, 0, got);
        check("lbu_0x11", got, 32'h0000_00BE);
        access(0, 0, 32'h13, 2'b00, 0, 32'h0, 0, got);
        check("lb_0x13", got, 32'hFFFF_FFDE);
        access(0, 1, 32'h20, 2'b10, 0, 32'h1122_3344, 0, got);
        access(0, 1, 32'h22, 2'b01, 0, 32'h0000_8001, 0, got);
        access(0, 0, 32'h20, 2'b10, 1, 32'h0, 0, got);
        check("lw_0x20", got, 32'h8001_3344);
        access(0, 0, 32'h22, 2'b01, 0, 32'h0, 0, got);
        check("lh_0x22", got, 32'hFFFF_8001);
        access(0, 0, 32'h22, 2'b01, 1, 32'h0, 0, got);
        check("lhu_0x22", got, 32'h0000_8001);

        // DEPTH=256 address wrap
        access(0, 1, 32'h400, 2'b10, 0, 32'hA5A5_A5A5, 0, got);
        access(0, 0, 32'h000, 2'b10, 0, 32'h0, 0, got);
        check("wrap_lw_0x0", got, 32'hA5A5_A5A5);

        // Alignment behaviour
        access(0, 0, 32'h2, 2'b10, 0, 32'h0, 0, got);
`ifdef DMEM_ALIGN_CHK_EN
        check("lw_0x2_dm_held", got, 32'hA5A5_A5A5);
`else
        check("lw_0x2_word0", got, 32'hA5A5_A5A5);
`endif
        access(0, 1, 32'h4, 2'b10, 0, 32'h5566_7788, 0, got);
        access(0, 1, 32'h5, 2'b01, 0, 32'h0000_BEEF, 0, got);
        access(0, 0, 32'h4, 2'b10, 0, 32'h0, 0, got);
`ifdef DMEM_ALIGN_CHK_EN
        check("sh_0x5_blocked", got, 32'h5566_7788);
`else
        check("sh_0x5_lane01", got, 32'h5566_BEEF);
`endif

        // LAT=3: held Req during WAIT, then reset mid-operation
        access(1, 1, 32'h8, 2'b10, 0, 32'hCAFE_F00D, 0, got);
        access(1, 0, 32'h8, 2'b10, 0, 32'h0, 1, got);
        check("held_lw_0x8", got, 32'hCAFE_F00D);
        req[1] = 1'b1; wr_s[1] = 1'b1; ad_s[1] = 32'h8; sz_s[1] = 2'b10; wd_s[1] = 32'h1234_5678;
        @(posedge clk);
        #1 req[1] = 1'b0;
        @(negedge clk);
        check("wait_ready_low", 32'(ready[1]), 32'd0);
        rst[1] = 1'b1;
        #1;
        check("midreset_outputs", {ready[1], rvalid[1], done[1], mis[1]}, 32'b1000);
        check("midreset_dm", dm[1], 32'd0);
        last_dm[1] = 32'd0;
        @(negedge clk);
        rst[1] = 1'b0;
        @(negedge clk);
        access(1, 0, 32'h8, 2'b10, 0, 32'h0, 0, got);
        check("reset_store_dropped", got, 32'hCAFE_F00D);

        // Randomized traffic over an initialized 64-byte window with aliasing
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) access(d, 1, 32'(4 * i), 2'b10, 0, $urandom, 0, got);
            for (int i = 0; i < 60; i++) begin
                access(d, 1'($urandom), 32'($urandom_range(0, 63) + $urandom_range(0, 3) * span_of(d)),
                       2'($urandom), 1'($urandom), $urandom, 0, got);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
